// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : Issue stage in front of the n-bit ALU. Decodes a 16-bit
//             instruction word, reads two operands from an 8-entry register
//             file, and blocks RAW/WAW hazards with a per-register pending
//             scoreboard. It hands one registered operation to the ALU over a
//             valid/ready handshake. Results come back through the writeback
//             port, which updates the register file and releases the
//             scoreboard entry.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock for all state
//    rst_n        in   asynchronous active-low reset
//    instr_valid  in   instruction word present
//    instr_ready  out  stage accepts the instruction this cycle
//    instr[15:0]  in   [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2,
//                      [3] carry-in, [2:0] reserved (ignored)
//    wb_en        in   writeback strobe
//    wb_addr[2:0] in   writeback register index
//    wb_data[n]   in   writeback value
//    iss_valid    out  issued operation valid toward the ALU
//    iss_ready    in   ALU side consumes the issued operation
//    in1_val[n]   out  operand A = R[rs1]
//    in2_val[n]   out  operand B = R[rs2], zero for unary ops
//    mux_in[2:0]  out  ALU op select
//    c_in         out  ALU carry-in
//    iss_rd[2:0]  out  destination index travelling with the operation
//    busy         out  at least one register has a result outstanding
// ============================================================================
module alu_operand_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  input  logic         wb_en,
  input  logic [2:0]   wb_addr,
  input  logic [n-1:0] wb_data,
  output logic         iss_valid,
  input  logic         iss_ready,
  output logic [n-1:0] in1_val,
  output logic [n-1:0] in2_val,
  output logic [2:0]   mux_in,
  output logic         c_in,
  output logic [2:0]   iss_rd,
  output logic         busy
);

  // Unary opcodes read only rs1; everything else is binary.
  localparam logic [2:0] c_OP_MOV = 3'b000;
  localparam logic [2:0] c_OP_NOT = 3'b001;
  localparam int         c_NREGS  = 8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [n-1:0]         r_regs [c_NREGS];
  logic [c_NREGS-1:0]   r_pending;
  logic                 r_iss_valid;
  logic [n-1:0]         r_in1;
  logic [n-1:0]         r_in2;
  logic [2:0]           r_mux;
  logic                 r_cin;
  logic [2:0]           r_rd;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic [2:0] w_op;
  logic [2:0] w_rd;
  logic [2:0] w_rs1;
  logic [2:0] w_rs2;
  logic       w_cin;
  logic       w_unary;
  logic       w_unused_reserved;

  assign w_op    = instr[15:13];
  assign w_rd    = instr[12:10];
  assign w_rs1   = instr[9:7];
  assign w_rs2   = instr[6:4];
  assign w_cin   = instr[3];
  assign w_unary = (w_op == c_OP_MOV) || (w_op == c_OP_NOT);

  // Reserved bits carry no meaning for this stage.
  assign w_unused_reserved = ^instr[2:0];

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  // A register whose writeback lands this cycle is no longer a hazard: the
  // bypass below supplies the fresh value, and for rd the write is ordered
  // before the new producer takes ownership.
  logic [c_NREGS-1:0] w_clr;
  logic [c_NREGS-1:0] w_set;
  logic [c_NREGS-1:0] w_pend_live;
  logic [c_NREGS-1:0] w_pending_nxt;
  logic               w_hazard;
  logic               w_slot_free;
  logic               w_accept;

  always_comb begin
    w_clr = '0;
    if (wb_en) begin
      w_clr[wb_addr] = 1'b1;
    end
  end

  assign w_pend_live = r_pending & ~w_clr;

  assign w_hazard = w_pend_live[w_rs1]
                  | (~w_unary & w_pend_live[w_rs2])
                  | w_pend_live[w_rd];

  // The output slot can take a new op when empty or being drained this cycle.
  assign w_slot_free = ~r_iss_valid | iss_ready;
  assign instr_ready = ~w_hazard & w_slot_free;
  assign w_accept    = instr_valid & instr_ready;

  always_comb begin
    w_set = '0;
    if (w_accept) begin
      w_set[w_rd] = 1'b1;
    end
  end

  // Set is OR-ed after the clear so a new producer keeps ownership when its
  // destination is written back in the same cycle.
  assign w_pending_nxt = w_pend_live | w_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign busy = |r_pending;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  // Writes happen regardless of scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Operand read with writeback bypass
  // --------------------------------------------------------------------------
  logic [n-1:0] w_rs1_val;
  logic [n-1:0] w_rs2_val;
  logic [n-1:0] w_in2_nxt;

  assign w_rs1_val = (wb_en && (wb_addr == w_rs1)) ? wb_data : r_regs[w_rs1];
  assign w_rs2_val = (wb_en && (wb_addr == w_rs2)) ? wb_data : r_regs[w_rs2];
  assign w_in2_nxt = w_unary ? '0 : w_rs2_val;

  // --------------------------------------------------------------------------
  // Issue register
  // --------------------------------------------------------------------------
  // Payload only loads on accept, so it stays stable under backpressure and
  // keeps its last value after the ALU drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_mux       <= '0;
      r_cin       <= 1'b0;
      r_rd        <= '0;
    end else if (w_accept) begin
      r_iss_valid <= 1'b1;
      r_in1       <= w_rs1_val;
      r_in2       <= w_in2_nxt;
      r_mux       <= w_op;
      r_cin       <= w_cin;
      r_rd        <= w_rd;
    end else if (iss_ready) begin
      r_iss_valid <= 1'b0;
    end
  end

  assign iss_valid = r_iss_valid;
  assign in1_val   = r_in1;
  assign in2_val   = r_in2;
  assign mux_in    = r_mux;
  assign c_in      = r_cin;
  assign iss_rd    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Directed self-checking bench for alu_operand_stage. Inputs are
//             driven 1 time unit after the rising edge and outputs are sampled
//             between edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  localparam int c_W = 32;

  logic           clk;
  logic           rst_n;
  logic           instr_valid;
  logic           instr_ready;
  logic [15:0]    instr;
  logic           wb_en;
  logic [2:0]     wb_addr;
  logic [c_W-1:0] wb_data;
  logic           iss_valid;
  logic           iss_ready;
  logic [c_W-1:0] in1_val;
  logic [c_W-1:0] in2_val;
  logic [2:0]     mux_in;
  logic           c_in;
  logic [2:0]     iss_rd;
  logic           busy;

  int n_checks;
  int n_fail;

  alu_operand_stage #(.n(c_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .in1_val     (in1_val),
    .in2_val     (in2_val),
    .mux_in      (mux_in),
    .c_in        (c_in),
    .iss_rd      (iss_rd),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic cin);
    mk = {op, rd, rs1, rs2, cin, 3'b000};
  endfunction

  task automatic wb(input logic [2:0] a, input logic [c_W-1:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    wb_en   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    iss_ready   = 1'b1;

    // Reset state
    #12;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in1", in1_val, 0);
    check("rst_mux", mux_in, 0);
    check("rst_iss_rd", iss_rd, 0);
    rst_n = 1'b1;
    step();

    // Load R1, R2
    wb(3'd1, 32'd421);
    wb(3'd2, 32'd3);

    // ADD rd3, r1, r2
    instr_valid = 1'b1;
    instr = mk(3'b010, 3'd3, 3'd1, 3'd2, 1'b0);
    #1;
    check("add_ready", instr_ready, 1);
    step();
    check("add_valid", iss_valid, 1);
    check("add_in1", in1_val, 421);
    check("add_in2", in2_val, 3);
    check("add_mux", mux_in, 3'b010);
    check("add_cin", c_in, 0);
    check("add_rd", iss_rd, 3);
    check("add_busy", busy, 1);

    // SUB rd4, r3, r1 stalls on R3 until its writeback, then bypasses
    instr = mk(3'b011, 3'd4, 3'd3, 3'd1, 1'b0);
    #1;
    check("raw_stall0", instr_ready, 0);
    step();
    check("raw_drain_valid", iss_valid, 0);
    check("raw_stall1", instr_ready, 0);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'd424;
    #1;
    check("raw_bypass_ready", instr_ready, 1);
    step();
    wb_en = 1'b0;
    check("sub_valid", iss_valid, 1);
    check("sub_in1", in1_val, 424);
    check("sub_in2", in2_val, 421);
    check("sub_mux", mux_in, 3'b011);
    check("sub_rd", iss_rd, 4);

    // Make R5 pending, then unary NOT ignores rs2=5 while binary stalls
    instr = mk(3'b010, 3'd5, 3'd1, 3'd2, 1'b0);
    step();
    check("add5_rd", iss_rd, 5);
    instr = mk(3'b100, 3'd7, 3'd1, 3'd5, 1'b0);
    #1;
    check("bin_rs2_stall", instr_ready, 0);
    instr = mk(3'b001, 3'd6, 3'd1, 3'd5, 1'b1);
    #1;
    check("not_ready", instr_ready, 1);
    step();
    check("not_in1", in1_val, 421);
    check("not_in2", in2_val, 0);
    check("not_mux", mux_in, 3'b001);
    check("not_cin", c_in, 1);
    check("not_rd", iss_rd, 6);

    // Backpressure: OR rd0 held for 3 cycles
    iss_ready = 1'b0;
    instr = mk(3'b101, 3'd0, 3'd1, 3'd2, 1'b0);
    #1;
    check("bp_ready0", instr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", iss_valid, 1);
      check("bp_ready", instr_ready, 0);
      check("bp_mux", mux_in, 3'b001);
      check("bp_rd", iss_rd, 6);
      check("bp_in2", in2_val, 0);
    end
    iss_ready = 1'b1;
    #1;
    check("bp_release_ready", instr_ready, 1);
    step();
    check("or_mux", mux_in, 3'b101);
    check("or_rd", iss_rd, 0);
    check("or_in2", in2_val, 3);
    check("or_cin", c_in, 0);

    // Set/clear collision on R3
    instr = mk(3'b010, 3'd3, 3'd1, 3'd2, 1'b0);
    step();
    check("coll_first_rd", iss_rd, 3);
    check("coll_waw_stall", instr_ready, 0);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'd7;
    #1;
    check("coll_ready", instr_ready, 1);
    step();
    wb_en = 1'b0;
    instr_valid = 1'b0;
    check("coll_busy", busy, 1);
    wb(3'd0, 32'd100);
    wb(3'd4, 32'd104);
    wb(3'd5, 32'd105);
    wb(3'd6, 32'd106);
    check("coll_r3_still_pending", busy, 1);
    instr_valid = 1'b1;
    instr = mk(3'b000, 3'd2, 3'd3, 3'd0, 1'b0);
    #1;
    check("coll_rs1_stall", instr_ready, 0);
    instr_valid = 1'b0;
    wb(3'd3, 32'd99);
    check("all_clear_busy", busy, 0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("mov_in1", in1_val, 99);
    check("mov_in2", in2_val, 0);
    check("mov_mux", mux_in, 3'b000);
    check("mov_busy", busy, 1);
    check("mov_valid", iss_valid, 1);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", iss_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in1", in1_val, 0);
    check("arst_in2", in2_val, 0);
    check("arst_rd", iss_rd, 0);
    #2;
    rst_n = 1'b1;
    step();
    instr_valid = 1'b1;
    instr = mk(3'b010, 3'd2, 3'd1, 3'd3, 1'b0);
    #1;
    check("arst_ready", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    check("arst_r1_zero", in1_val, 0);
    check("arst_r3_zero", in2_val, 0);
    check("arst_add_valid", iss_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the n-bit ALU.
- Accepts 16-bit instruction words and reads operands from an 8-entry register file.
- Uses a per-register scoreboard to block RAW/WAW hazards against results not yet written back.
- Presents one registered operation (in1_val, in2_val, mux_in, c_in) to the ALU under a valid/ready handshake; the downstream writeback port updates the register file.

Parameters:
n, 32, datapath width; matches ALU in1_val/in2_val/out1_val width.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction word present
instr_ready  output  1  stage accepts instruction this cycle
instr  input  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] cin, [2:0] reserved (ignored)
wb_en  input  1  writeback strobe
wb_addr  input  3  writeback register index
wb_data  input  n  writeback value (ALU out1_val after downstream capture)
iss_valid  output  1  issued operation valid toward ALU
iss_ready  input  1  ALU side consumes issued operation
in1_val  output  n  operand A = R[rs1]
in2_val  output  n  operand B = R[rs2], forced 0 for unary ops
mux_in  output  3  ALU op select = instr[15:13]
c_in  output  1  carry-in = instr[3]
iss_rd  output  3  destination index travelling with the operation
busy  output  1  OR of all scoreboard pending bits

Behaviour:
- Reset (async, rst_n=0):
  - All 8 registers = 0, pending[7:0] = 0.
  - iss_valid=0, in1_val=0, in2_val=0, mux_in=0, c_in=0, iss_rd=0, busy=0.
  - Reset mid-operation discards the issued op and all scoreboard state immediately; there is no partial writeback.
- Op classes:
  - Unary: 000 MOV, 001 NOT. Only rs1 is read; rs2 is ignored for hazards and in2_val=0.
  - Binary: all other codes. Read rs1 and rs2.
- Register file write: when wb_en=1, R[wb_addr] <= wb_data at the clock edge, regardless of pending state. Writes to non-pending registers are legal and silent.
- Bypass: if wb_en=1 and wb_addr matches a source index on the accept cycle, that operand takes wb_data, not the stale array value.
- Scoreboard:
  - pending[wb_addr] clears on wb_en.
  - pending[rd] sets on accept.
  - Same register set and cleared in the same cycle: set wins, so the new producer owns it.
- Hazard (combinational, from the current instr):
  - hazard = (pending[rs1] & !clr(rs1)) | (binary & pending[rs2] & !clr(rs2)) | (pending[rd] & !clr(rd)).
  - clr(x) = wb_en & (wb_addr==x).
- Handshake:
  - instr_ready = !hazard & (!iss_valid | iss_ready). instr_ready depends on instr, so the upstream source must hold instr stable while instr_valid=1.
  - Accept = instr_valid & instr_ready.
  - On accept, output registers load at the next edge and iss_valid=1. Latency is 1 cycle from accept to iss_valid.
  - If iss_valid & iss_ready & !accept, then iss_valid <= 0. Outputs hold their last values.
  - While iss_valid=1 & iss_ready=0, all iss outputs are held stable and no new accept occurs.
  - Back-to-back: with iss_ready=1 and no hazards, one instruction per cycle.
- Dependent instructions stall until writeback, because there is no ALU-result forwarding. A back-to-back RAW pair therefore issues with a gap ≥ the writeback latency.
- Width rules: operands pass through unmodified at n bits. Index fields are 3 bits, with no wrap or out-of-range cases.
- busy = |pending, registered view of the scoreboard after the edge.

Test Plan:
- Reset, then wb R1=32'd421 and R2=32'd3. Issue ADD rd=3,rs1=1,rs2=2,cin=0 → next cycle iss_valid=1, in1_val=421, in2_val=3, mux_in=010, iss_rd=3, busy=1.
- RAW stall: after ADD rd=3 issues, present SUB rd=4,rs1=3,rs2=1 → instr_ready=0 until wb_en addr=3 data=424. In that wb cycle instr_ready=1 (bypass) and in1_val=424 on issue.
- Unary: R5 pending; issue NOT rd=6,rs1=1,rs2=5 → accepted without stall, in2_val=0, mux_in=001.
- Backpressure: iss_ready=0 for 3 cycles with instr_valid held → instr_ready=0 and outputs stable. iss_ready=1 → next instruction issues in the following cycle.
- Set/clear collision: wb_en addr=3 in the same cycle an ADD rd=3 is accepted (pending[3] was 1) → pending[3] stays 1, busy=1.
- Async reset asserted while iss_valid=1 and pending≠0 → iss_valid=0, busy=0, and all registers read 0 immediately without a clock edge.
